// File: rtl/apb_cfg_initiator_pkg.sv
// Shared encodings for the cfg-register APB initiator.
package apb_cfg_initiator_pkg;

    localparam int unsigned TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        GAP,
        RESP
    } state_t;

    // The reserved opcode behaves exactly like a read.
    function automatic op_t decode_op(input logic [1:0] raw);
        return (raw == 2'd3) ? OP_READ : op_t'(raw);
    endfunction

endpackage

// File: rtl/apb_cfg_initiator_if.sv
// Host command/response channel plus APB master signals for apb_cfg_initiator.
interface apb_cfg_initiator_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;
    logic [DATA_W-1:0] cmd_match;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
        input  rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
        output rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

endinterface

// File: rtl/apb_poll_counter.sv
// Inter-poll gap down-counter and saturating poll-read counter.
module apb_poll_counter #(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned POLL_MAX = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic gap_load,
    input  logic gap_dec,
    input  logic poll_clr,
    input  logic poll_inc,
    output logic gap_done,
    output logic poll_last
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] poll_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt  <= '0;
            poll_cnt <= '0;
        end else begin
            if (gap_load) begin
                gap_cnt <= GAP_W'(POLL_GAP - 1);
            end else if (gap_dec && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (poll_clr) begin
                poll_cnt <= '0;
            end else if (poll_inc && poll_cnt != CNT_W'(POLL_MAX)) begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end

    assign gap_done  = (gap_cnt == '0);
    // Sampled before the increment: true while the POLL_MAX-th read is in flight.
    assign poll_last = (poll_cnt >= CNT_W'(POLL_MAX - 1));

endmodule

// File: rtl/apb_cfg_initiator.sv
// APB initiator turning host write/read/poll commands into cfg-register transfers.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_cfg_initiator
    import apb_cfg_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned POLL_MAX = 256
) (
    input logic                 clk,
    input logic                 reset,
    apb_cfg_initiator_if.master bus
);

    state_t            state;
    op_t               op_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] match_q;
    logic              accept;
    logic              poll_hit;
    logic              gap_done;
    logic              poll_last;
`ifdef APB_TIMEOUT_EN
    logic [15:0]       to_cnt;
`endif

    assign accept   = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign poll_hit = ((bus.PRDATA ^ match_q) & mask_q) == '0;

    apb_poll_counter #(
        .POLL_GAP (POLL_GAP),
        .POLL_MAX (POLL_MAX)
    ) u_poll_counter (
        .clk       (clk),
        .reset     (reset),
        .gap_load  ((state == ACCESS) && bus.PREADY),
        .gap_dec   (state == GAP),
        .poll_clr  (accept),
        .poll_inc  ((state == ACCESS) && bus.PREADY && (op_q == OP_POLL)),
        .gap_done  (gap_done),
        .poll_last (poll_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= OP_WRITE;
            mask_q        <= '0;
            match_q       <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (accept) begin
                        op_q          <= decode_op(bus.cmd_op);
                        mask_q        <= bus.cmd_mask;
                        match_q       <= bus.cmd_match;
                        bus.PADDR     <= bus.cmd_addr;
                        bus.PWDATA    <= bus.cmd_wdata;
                        bus.PWRITE    <= (bus.cmd_op == OP_WRITE);
                        bus.PSEL      <= 1'b1;
                        bus.PENABLE   <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_rdata <= (op_q == OP_WRITE) ? '0 : bus.PRDATA;
                        // A match on the final permitted read wins over exhaustion.
                        if (op_q != OP_POLL || poll_hit) begin
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else if (poll_last) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_done) begin
                        bus.PSEL <= 1'b1;
                        state    <= SETUP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_initiator.sv
// Directed bench for apb_cfg_initiator: vector table plus hand-written latency/reset sequences.
module tb_apb_cfg_initiator;
    import apb_cfg_initiator_pkg::*;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned POLL_GAP = 4;
    localparam int unsigned POLL_MAX = 4;
    localparam logic [31:0] JUNK     = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb_cfg_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cfg_initiator #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .POLL_GAP (POLL_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model configuration and observations
    int unsigned slv_waits  = 0;
    int unsigned slv_hit_at = 1;
    logic [31:0] slv_miss   = '0;
    logic [31:0] slv_hit    = '0;
    logic [7:0]  exp_addr   = '0;
    logic        exp_write  = 1'b0;
    logic [31:0] exp_wdata  = '0;
    int unsigned xfers      = 0;
    int unsigned acc_cyc    = 0;
    int unsigned gaps[$];

    initial begin : apb_slave
        int unsigned wcnt;
        int unsigned low_run;
        wcnt    = 0;
        low_run = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = JUNK;
        forever begin
            @(posedge clk);
            #1;
            if (bus.PSEL && bus.PENABLE) begin
                chk("apb_paddr",  32'(bus.PADDR),  32'(exp_addr));
                chk("apb_pwrite", 32'(bus.PWRITE), 32'(exp_write));
                chk("apb_pwdata", bus.PWDATA,      exp_wdata);
                acc_cyc++;
                low_run    = 0;
                bus.PREADY = (wcnt >= slv_waits);
                bus.PRDATA = (xfers + 1 >= slv_hit_at) ? slv_hit : slv_miss;
                wcnt++;
                if (bus.PREADY) xfers++;
            end else begin
                wcnt       = 0;
                bus.PREADY = 1'b0;
                bus.PRDATA = JUNK;
                if (bus.PSEL) begin
                    if (xfers > 0) gaps.push_back(low_run);
                    low_run = 0;
                end else begin
                    low_run++;
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] match;
        int unsigned waits;
        int unsigned hit_at;
        logic [31:0] miss_data;
        logic [31:0] hit_data;
        logic        early_rdy;
        int unsigned hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_reads;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mask,
                                input logic [31:0] match, input int unsigned waits,
                                input int unsigned hit_at, input logic [31:0] miss_data,
                                input logic [31:0] hit_data, input logic early_rdy,
                                input int unsigned hold, input logic [31:0] exp_rdata,
                                input logic exp_err, input int unsigned exp_reads);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.mask = mask; v.match = match;
        v.waits = waits; v.hit_at = hit_at; v.miss_data = miss_data; v.hit_data = hit_data;
        v.early_rdy = early_rdy; v.hold = hold; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_reads = exp_reads;
        return v;
    endfunction

    task automatic setup_slave(input vec_t v);
        slv_waits  = v.waits;
        slv_hit_at = v.hit_at;
        slv_miss   = v.miss_data;
        slv_hit    = v.hit_data;
        exp_addr   = v.addr;
        exp_write  = (v.op == 2'd0);
        exp_wdata  = v.wdata;
        xfers      = 0;
        acc_cyc    = 0;
        gaps.delete();
    endtask

    task automatic issue(input vec_t v);
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_mask  = v.mask;
        bus.cmd_match = v.match;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (bus.rsp_valid) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input int unsigned idx, input vec_t v);
        int unsigned exp_gaps;
        setup_slave(v);
        bus.rsp_ready = v.early_rdy;
        chk($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
        issue(v);
        chk($sformatf("v%0d_setup", idx), {30'd0, bus.PSEL, bus.PENABLE}, 32'b10);
        wait_rsp(2000);
        chk($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_psel_resp", idx), 32'(bus.PSEL), 32'd0);
        chk($sformatf("v%0d_reads", idx), xfers, v.exp_reads);
        exp_gaps = (v.exp_reads > 0) ? v.exp_reads - 1 : 0;
        chk($sformatf("v%0d_gap_count", idx), gaps.size(), exp_gaps);
        foreach (gaps[g]) chk($sformatf("v%0d_gap%0d", idx, g), gaps[g], POLL_GAP);
        for (int unsigned h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_hold_valid", idx), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("v%0d_hold_rdata", idx), bus.rsp_rdata, v.exp_rdata);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk($sformatf("v%0d_valid_drop", idx), 32'(bus.rsp_valid), 32'd0);
        chk($sformatf("v%0d_ready_after", idx), 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[8];
    vec_t t;

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_mask  = '0;
        bus.cmd_match = '0;
        bus.rsp_ready = 1'b0;

        //          op       addr   wdata         mask          match         wt hit miss          hit           er hold rdata         err reads
        vecs[0] = mk(OP_WRITE, 8'h04, 32'h0000_0013, 32'h0,        32'h0,        0, 1,  JUNK,         32'h1111_2222, 0, 0, 32'h0,         0, 1);
        vecs[1] = mk(OP_READ,  8'h08, 32'h0,         32'h0,        32'h0,        3, 1,  JUNK,         32'hDEAD_BEEF, 0, 5, 32'hDEAD_BEEF, 0, 1);
        vecs[2] = mk(OP_POLL,  8'h00, 32'h0,         32'h8000_0000, 32'h8000_0000, 0, 3, 32'h0000_0001, 32'h8000_0005, 0, 0, 32'h8000_0005, 0, 3);
        vecs[3] = mk(OP_POLL,  8'h0C, 32'h0,         32'h0000_00FF, 32'h0000_00A5, 1, 99, 32'h0000_005A, 32'h0000_00A5, 0, 0, 32'h0000_005A, 1, 4);
        vecs[4] = mk(OP_RSVD,  8'h10, 32'h0,         32'h0,        32'h0,        1, 1,  JUNK,         32'h1234_5678, 1, 0, 32'h1234_5678, 0, 1);
        vecs[5] = mk(OP_POLL,  8'h14, 32'h0,         32'h0000_000F, 32'h0000_0003, 0, 4, 32'h0000_0000, 32'h0000_0013, 0, 0, 32'h0000_0013, 0, 4);
        vecs[6] = mk(OP_POLL,  8'h18, 32'h0,         32'hFFFF_0000, 32'hCAFE_1234, 2, 1, JUNK,         32'hCAFE_0000, 0, 0, 32'hCAFE_0000, 0, 1);
        vecs[7] = mk(OP_WRITE, 8'hFF, 32'hFFFF_FFFF, 32'h0,        32'h0,        2, 1,  32'hBAD0_BAD0, 32'hBAD0_BAD0, 0, 1, 32'h0,         0, 1);

        // Reset values, then cmd_ready one cycle after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_psel",      32'(bus.PSEL),      32'd0);
        chk("rst_penable",   32'(bus.PENABLE),   32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_paddr",     32'(bus.PADDR),     32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // WRITE minimum latency, cycle by cycle
        t = vecs[0];
        setup_slave(t);
        issue(t);
        chk("lat_t1_psel",    32'(bus.PSEL),      32'd1);
        chk("lat_t1_penable", 32'(bus.PENABLE),   32'd0);
        chk("lat_t1_pwrite",  32'(bus.PWRITE),    32'd1);
        chk("lat_t1_pwdata",  bus.PWDATA,         32'h13);
        chk("lat_t1_ready",   32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_t2_psel",    32'(bus.PSEL),      32'd1);
        chk("lat_t2_penable", 32'(bus.PENABLE),   32'd1);
        chk("lat_t2_pwdata",  bus.PWDATA,         32'h13);
        chk("lat_t2_valid",   32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_t3_valid",   32'(bus.rsp_valid), 32'd1);
        chk("lat_t3_err",     32'(bus.rsp_err),   32'd0);
        chk("lat_t3_rdata",   bus.rsp_rdata,      32'd0);
        chk("lat_t3_psel",    32'(bus.PSEL),      32'd0);
        chk("lat_t3_ready",   32'(bus.cmd_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("lat_t4_ready",   32'(bus.cmd_ready), 32'd1);

        for (int unsigned i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while in ACCESS: command dropped, no response
        t = mk(OP_READ, 8'h20, 32'h0, 32'h0, 32'h0, 10, 1, JUNK, 32'h5555_AAAA, 0, 0, 32'h0, 0, 0);
        setup_slave(t);
        issue(t);
        @(posedge clk);
        #1;
        chk("mid_in_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'b11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_psel",      32'(bus.PSEL),      32'd0);
        chk("mid_penable",   32'(bus.PENABLE),   32'd0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_rsp",    32'(bus.rsp_valid), 32'd0);
        run_vec(8, mk(OP_WRITE, 8'h24, 32'hA5A5_0001, 32'h0, 32'h0, 1, 1, JUNK, JUNK, 0, 0, 32'h0, 0, 1));

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abandoned after 1024 ACCESS cycles
        run_vec(9, mk(OP_POLL, 8'h30, 32'h0, 32'h1, 32'h1, 5000, 1, JUNK, 32'h1, 0, 0, 32'h0, 1, 0));
        chk("to_access_cycles", acc_cyc, 32'd1024);
        run_vec(10, vecs[1]);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_cfg_initiator.md
Name: apb_cfg_initiator

Overview:
- APB initiator that drives the accelerator's configuration register slave (PADDR/PWRITE/PSEL/PENABLE/PWDATA out; PRDATA/PREADY in).
- Turns single-command requests from a host sequencer into APB writes, reads, or poll-reads (repeat read until a masked match). An example poll-read is waiting on done_tpu.
- Sits on the host side of the cfg register bus, on the same clk as the accelerator.

Parameters:
- ADDR_W, 8 (matches `REG_ADDRWIDTH), PADDR width.
- DATA_W, 32 (matches `REG_DATAWIDTH), PWDATA/PRDATA width.
- POLL_GAP, 4, idle cycles between successive poll reads (>=1).
- POLL_MAX, 256, maximum poll reads before giving up.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  initiator can accept a command.
- cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved (treated as READ).
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data (WRITE only).
- cmd_mask  in  DATA_W  poll compare mask.
- cmd_match  in  DATA_W  poll compare value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  DATA_W  captured PRDATA (0 for WRITE).
- rsp_err  out  1  poll exhausted or timeout.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready, which is 0 during reset and 1 in the first cycle after reset deasserts. FSM returns to IDLE. Reset mid-transfer drops PSEL/PENABLE in the next cycle and discards the command with no response.
- Command latch: on cmd_valid&&cmd_ready, latch op/addr/wdata/mask/match. cmd_ready=1 only in IDLE.
- IDLE: on accept, go to SETUP. PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from latched values; PWRITE=1 only for WRITE.
- SETUP: exactly one cycle, then ACCESS with PENABLE=1.
- ACCESS: hold all APB outputs stable while PREADY=0. On PREADY=1:
  - Capture PRDATA for READ/POLL.
  - Deassert PSEL/PENABLE in the next cycle.
  - WRITE/READ go to RESP.
  - POLL goes to RESP if (PRDATA&mask)==(match&mask). Otherwise go to RESP with rsp_err=1 if the poll count has reached POLL_MAX, else to GAP.
- GAP: PSEL=0 for POLL_GAP cycles, then SETUP with the same address. The poll counter increments per completed read.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready; then IDLE. cmd_ready stays 0 until the cycle after the handshake.
- Minimum latency:
  - WRITE: accept@T, SETUP T+1, ACCESS T+2 with PREADY=1, rsp_valid@T+3.
  - READ: same timing as WRITE.
- Back-to-back commands: at least one IDLE cycle with PSEL=0 between transfers.
- Poll width rules:
  - The poll counter is wide enough for POLL_MAX and saturates.
  - A match on read number POLL_MAX takes priority over the error.
- rsp_ready asserted before rsp_valid has no effect.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined: a 16-bit counter runs in ACCESS. After 1024 consecutive cycles with PREADY=0, the block drops PSEL/PENABLE, goes to RESP with rsp_err=1 and rsp_rdata=0, and abandons any poll.
- Without the macro: ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package/defines file holds:
  - op encodings: OP_WRITE=0, OP_READ=1, OP_POLL=2.
  - FSM state encodings: IDLE, SETUP, ACCESS, GAP, RESP.
  - TIMEOUT_CYCLES=1024.
- One natural sub-module, apb_poll_counter. It holds the gap down-counter and the saturating poll counter, with load/decrement/done outputs.
- The FSM and APB drive stay in apb_cfg_initiator.

Test Plan:
1. WRITE addr=0x04 wdata=0x0000_0013 with a zero-wait slave -> PSEL rises at T+1, PENABLE at T+2, PWRITE=1 and PWDATA=0x13 stable; rsp_valid@T+3 with rsp_err=0 and rsp_rdata=0.
2. READ addr=0x08 with slave PREADY low for 3 cycles and PRDATA=0xDEAD_BEEF -> PADDR/PSEL stable across wait states; rsp_rdata=0xDEADBEEF; rsp_valid held 5 cycles while rsp_ready=0, then cmd_ready=1 the cycle after the handshake.
3. POLL addr=0x00 mask=0x8000_0000 match=0x8000_0000, slave returns bit31=1 on the 3rd read -> 3 APB reads each separated by 4 PSEL-low cycles; rsp_err=0 and rsp_rdata has bit31 set.
4. POLL that never matches with POLL_MAX=4 -> exactly 4 APB reads, then rsp_err=1.
5. Reset asserted during ACCESS -> PSEL=PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 after release; a following WRITE completes normally.
6. (APB_TIMEOUT_EN) Slave holds PREADY=0 -> after 1024 ACCESS cycles PSEL drops, rsp_err=1, rsp_rdata=0.
